sine_dds_lut: RTL and testbench
===============================

# sine_dds_lut

Parametrised direct-digital-synthesis sine source built on a quarter-wave look-up table. A phase accumulator advances by a programmable tuning word. The top phase bits drive a quarter-wave table with quadrant reflection and sign restoration, producing a registered two's-complement full-wave sine sample with a valid strobe. It is the next-generation sine source for the lab designs, generalised in phase, table depth and amplitude width, and adding frequency/phase control and a pipelined output.

## Interface
- PHASE_W, 8 — accumulator / tuning-word width; must be ≥ LUT_AW+2 (elaboration error otherwise)
- LUT_AW, 3 — quarter-wave table address width (2^LUT_AW entries); range 2..8
- OUT_W, 4 — magnitude width; SINE_OUT is OUT_W+1 bits signed
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-high
- EN  in  1  advance accumulator and launch one sample this cycle
- LOAD  in  1  synchronous phase restart (accumulator treated as 0)
- FREQ  in  PHASE_W  tuning word, unsigned, added modulo 2^PHASE_W
- PHASE_OFS  in  PHASE_W  phase offset added to sampled phase, modulo 2^PHASE_W
- SINE_OUT  out  OUT_W+1  signed sample, registered
- VALID  out  1  one-cycle strobe: SINE_OUT updated this cycle
- PHASE  out  PHASE_W  current accumulator value

## Operation
- Table: Q[k] = round((2^OUT_W−1)·sin((2k+1)·π/2^(LUT_AW+2))), k = 0..2^LUT_AW−1. Midpoint sampling means no zero or duplicated-peak entry and exact quadrant symmetry. The table is built at elaboration by a constant function; nothing is stored at run time. Defaults: 1,4,7,10,12,13,14,15.
- Phase index p = (acc_sel + PHASE_OFS) mod 2^PHASE_W, where acc_sel = 0 if LOAD else ACC. Fields:
  - s = p[PHASE_W−1] (sign)
  - r = p[PHASE_W−2] (reflect)
  - a = p[PHASE_W−3 : PHASE_W−2−LUT_AW]
  - low bits are truncated, not rounded.
- Magnitude m = Q[r ? ~a : a]. Sample = s ? −m : m, computed in OUT_W+1 bits; it never overflows because m ≤ 2^OUT_W−1.
- Accumulator update (priority order):
  - RST: ACC ← 0
  - LOAD & EN: ACC ← FREQ
  - LOAD: ACC ← 0
  - EN: ACC ← ACC+FREQ
  - otherwise hold
- Wrap-around of ACC and p is silent modulo 2^PHASE_W.
- Pipeline (no stall, no backpressure):
  - Stage 1: {p, v1 ← EN}
  - Stage 2: {s, m, v2 ← v1}
  - Output: SINE_OUT ← sample, VALID ← v2
  - SINE_OUT and every stage register update only when its valid input is 1 and hold otherwise; VALID is 0 when v2 is 0.
- FREQ and PHASE_OFS are sampled only on EN cycles; changing them mid-run affects only later samples. There is no glitch or flush.
- LOAD without EN restarts the phase but launches no sample.
- Reset values: ACC, PHASE, SINE_OUT, VALID and all pipeline registers are 0.

## Timing
- EN sampled high at edge n → SINE_OUT/VALID updated at edge n+2. Latency is 2 cycles; throughput is 1 sample/cycle.
- PHASE reflects the post-update ACC from edge n onward.
- The sample launched at edge n uses the pre-update ACC, or 0 if LOAD.
- RST high at edge n clears all in-flight samples. No VALID follows at n+1 or n+2 unless EN is sampled after reset.
- RST dominates EN and LOAD in the same cycle.
- EN gaps propagate as VALID gaps with identical spacing; SINE_OUT holds its last value across gaps.

## Test plan
- Defaults, RST then EN=1 continuous, FREQ=8, PHASE_OFS=0:
  - First VALID 2 cycles after first EN edge.
  - Samples 1,4,7,10,12,13,14,15,15,14,13,12,10,7,4,1,−1,−4,…,−15,−15,…,−1, repeating.
  - Period is 32 samples; PHASE wraps 0xF8→0x00.
- FREQ=0xF8 (reverse rotation) from reset → samples 1,−1,−4,−7,… with no glitch at the wrap.
- FREQ=0, PHASE_OFS=0x40 → constant 15.
- FREQ=0, PHASE_OFS=0xC0 → constant −15.
- EN toggled 1,0,1,0 with FREQ=8 → VALID pattern 1,0,1,0 delayed 2 cycles; SINE_OUT 1,hold,4,hold.
- After 5 samples assert LOAD&EN for one cycle → that sample = 1, next = 4; PHASE = 0x08 after the LOAD edge.
- RST asserted while 2 samples are in flight → VALID stays 0 and SINE_OUT = 0 for the next 2 cycles.
- Parameter sweep PHASE_W=12, LUT_AW=5, OUT_W=7, random FREQ/PHASE_OFS/EN, 10k cycles → bit-exact match to the reference model formula above.

Source files
------------

// File: rtl/sine_dds_lut.sv
// sine_dds_lut: phase-accumulator sine source using a midpoint-sampled
// quarter-wave table with quadrant reflection and a two-stage registered output.
module sine_dds_lut #(
    parameter int PHASE_W = 8,
    parameter int LUT_AW  = 3,
    parameter int OUT_W   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               LOAD,
    input  logic [PHASE_W-1:0] FREQ,
    input  logic [PHASE_W-1:0] PHASE_OFS,
    output logic [OUT_W:0]     SINE_OUT,
    output logic               VALID,
    output logic [PHASE_W-1:0] PHASE
);
    localparam int QN = 1 << LUT_AW;
    localparam int TW = LUT_AW + 2;

    if (PHASE_W < LUT_AW + 2) begin : g_bad_pw
        $error("PHASE_W must be at least LUT_AW+2");
    end
    if (LUT_AW < 2 || LUT_AW > 8) begin : g_bad_aw
        $error("LUT_AW must lie in 2..8");
    end

    // Taylor series keeps the table build to plain real arithmetic
    function automatic int q_entry(input int k);
        real x;
        real term;
        real sum;
        x    = (2.0 * real'(k) + 1.0) * 3.14159265358979323846 / real'(4 * QN);
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return $rtoi(sum * real'((1 << OUT_W) - 1) + 0.5);
    endfunction

    logic [OUT_W-1:0] qtab [QN];

    for (genvar k = 0; k < QN; k++) begin : g_tab
        localparam int QV = q_entry(k);
        assign qtab[k] = QV[OUT_W-1:0];
    end

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] p_next;
    logic [TW-1:0]      p_top;
    logic [TW-1:0]      p1;
    logic               v1;
    logic               v2;
    logic               s2;
    logic [OUT_W-1:0]   m2;
    logic [LUT_AW-1:0]  a;
    logic [LUT_AW-1:0]  idx;

    assign p_next = (LOAD ? '0 : acc) + PHASE_OFS;
    // Only the sign, reflect and address bits travel down the pipe
    assign p_top  = TW'(p_next >> (PHASE_W - TW));
    assign a      = p1[LUT_AW-1:0];
    assign idx    = p1[TW-2] ? ~a : a;
    assign PHASE  = acc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc      <= '0;
            p1       <= '0;
            v1       <= 1'b0;
            s2       <= 1'b0;
            m2       <= '0;
            v2       <= 1'b0;
            SINE_OUT <= '0;
            VALID    <= 1'b0;
        end else begin
            if (LOAD) begin
                acc <= EN ? FREQ : '0;
            end else if (EN) begin
                acc <= acc + FREQ;
            end
            v1 <= EN;
            if (EN) begin
                p1 <= p_top;
            end
            v2 <= v1;
            if (v1) begin
                s2 <= p1[TW-1];
                m2 <= qtab[idx];
            end
            VALID <= v2;
            if (v2) begin
                SINE_OUT <= s2 ? -{1'b0, m2} : {1'b0, m2};
            end
        end
    end

endmodule

// File: tb/tb_sine_dds_lut.sv
// Bench for sine_dds_lut: default and widened instances against a
// trigonometric reference model, plus directed waveform checks.
module tb_sine_dds_lut;
    localparam int NONE = 32'h7fff_ffff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              en0, ld0, en1, ld1;
    logic [7:0]        f0, o0, ph0;
    logic [11:0]       f1, o1, ph1;
    logic signed [4:0] s0;
    logic signed [7:0] s1;
    logic              v0, v1;

    int     checks = 0;
    int     errors = 0;
    longint acc [2];
    int     last [2];
    int     hist [2][2];
    bit     vexp [2];

    sine_dds_lut dut0 (
        .CLK(clk), .RST(rst), .EN(en0), .LOAD(ld0),
        .FREQ(f0), .PHASE_OFS(o0),
        .SINE_OUT(s0), .VALID(v0), .PHASE(ph0)
    );

    sine_dds_lut #(.PHASE_W(12), .LUT_AW(5), .OUT_W(7)) dut1 (
        .CLK(clk), .RST(rst), .EN(en1), .LOAD(ld1),
        .FREQ(f1), .PHASE_OFS(o1),
        .SINE_OUT(s1), .VALID(v1), .PHASE(ph1)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_sample(input int id, input longint p);
        int  pw, aw, ow, s, r, a, ix, m;
        real x;
        pw = id ? 12 : 8;
        aw = id ? 5 : 3;
        ow = id ? 7 : 4;
        s  = int'((p >> (pw - 1)) & 1);
        r  = int'((p >> (pw - 2)) & 1);
        a  = int'((p >> (pw - 2 - aw)) & ((1 << aw) - 1));
        ix = r ? ((1 << aw) - 1 - a) : a;
        x  = real'((1 << ow) - 1) *
             $sin(real'(2 * ix + 1) * 3.14159265358979 / real'(1 << (aw + 2)));
        m  = $rtoi(x + 0.5);
        return s ? -m : m;
    endfunction

    function automatic void model_edge(input int id, input bit r, input bit e,
                                       input bit l, input longint f,
                                       input longint o);
        longint mask;
        int     launched, front;
        mask = (longint'(1) << (id ? 12 : 8)) - 1;
        if (r) begin
            acc[id]     = 0;
            hist[id][0] = NONE;
            hist[id][1] = NONE;
            vexp[id]    = 1'b0;
            last[id]    = 0;
            return;
        end
        launched = e ? ref_sample(id, ((l ? 0 : acc[id]) + o) & mask) : NONE;
        if (l) acc[id] = e ? f : 0;
        else if (e) acc[id] = (acc[id] + f) & mask;
        front       = hist[id][0];
        hist[id][0] = hist[id][1];
        hist[id][1] = launched;
        vexp[id]    = (front != NONE);
        if (vexp[id]) last[id] = front;
    endfunction

    task automatic cyc(input logic r, input logic e, input logic l,
                       input logic [7:0] f, input logic [7:0] o);
        rst = r;
        en0 = e;
        ld0 = l;
        f0  = f;
        o0  = o;
        en1 = ($urandom_range(0, 3) != 0);
        ld1 = ($urandom_range(0, 15) == 0);
        f1  = 12'($urandom);
        o1  = 12'($urandom);
        @(posedge clk);
        model_edge(0, r, e, l, longint'(f), longint'(o));
        model_edge(1, r, en1, ld1, longint'(f1), longint'(o1));
        #1;
        check("valid0", v0, vexp[0]);
        check("sine0", s0, last[0]);
        check("phase0", ph0, acc[0]);
        check("valid1", v1, vexp[1]);
        check("sine1", s1, last[1]);
        check("phase1", ph1, acc[1]);
    endtask

    function automatic int seq_exp(input int k);
        int pos [8];
        int q, i;
        pos = '{1, 4, 7, 10, 12, 13, 14, 15};
        q = (k / 8) % 4;
        i = k % 8;
        case (q)
            0: return pos[i];
            1: return pos[7 - i];
            2: return -pos[i];
            default: return -pos[7 - i];
        endcase
    endfunction

    initial begin
        int n;
        int rev [4];
        rev = '{1, -1, -4, -7};

        cyc(1, 0, 0, 8'h00, 8'h00);
        cyc(1, 0, 0, 8'h00, 8'h00);
        check("rst_valid", v0, 0);
        check("rst_sine", s0, 0);
        check("rst_phase", ph0, 0);

        n = 0;
        for (int i = 0; i < 34; i++) begin
            cyc(0, 1, 0, 8'h08, 8'h00);
            if (v0) begin
                check("seq", s0, seq_exp(n));
                n++;
            end
        end
        check("seq_count", n, 32);

        cyc(1, 0, 0, 8'h00, 8'h00);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 8'hF8, 8'h00);
            if (v0 && n < 4) begin
                check("reverse", s0, rev[n]);
                n++;
            end
        end

        cyc(1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'h00, 8'h40);
        check("const_pos", s0, 15);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'h00, 8'hC0);
        check("const_neg", s0, -15);

        cyc(1, 0, 0, 8'h00, 8'h00);
        cyc(0, 1, 0, 8'h08, 8'h00);
        cyc(0, 0, 0, 8'h08, 8'h00);
        cyc(0, 1, 0, 8'h08, 8'h00);
        check("gap_v_a", v0, 1);
        check("gap_s_a", s0, 1);
        cyc(0, 0, 0, 8'h08, 8'h00);
        check("gap_v_b", v0, 0);
        check("gap_s_b", s0, 1);
        cyc(0, 0, 0, 8'h08, 8'h00);
        check("gap_s_c", s0, 4);
        cyc(0, 0, 0, 8'h08, 8'h00);
        check("gap_v_d", v0, 0);

        cyc(1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'h08, 8'h00);
        cyc(0, 1, 1, 8'h08, 8'h00);
        check("load_phase", ph0, 8);
        cyc(0, 1, 0, 8'h08, 8'h00);
        cyc(0, 1, 0, 8'h08, 8'h00);
        check("load_sample", s0, 1);
        cyc(0, 1, 0, 8'h08, 8'h00);
        check("load_next", s0, 4);

        cyc(0, 1, 0, 8'h08, 8'h00);
        cyc(1, 0, 0, 8'h08, 8'h00);
        cyc(0, 0, 0, 8'h08, 8'h00);
        check("flush_v1", v0, 0);
        check("flush_s1", s0, 0);
        cyc(0, 0, 0, 8'h08, 8'h00);
        check("flush_v2", v0, 0);
        check("flush_s2", s0, 0);

        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 31) == 0), 8'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
